// File: rtl/hazard_ctrl_pkg.sv
// Shared types and widths for the pipeline hazard controller.
// State encodings and register-index width live here so decode and control agree.
package hazard_ctrl_pkg;

  localparam int RFIDX_WIDTH = 5;
  localparam int XLEN        = 32;

  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_MDU_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
// It holds at all-ones instead of wrapping, so long stalls never read as short ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (en && (cnt != {WIDTH{1'b1}})) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, EX redirect flush, MDU wait with timeout.
// The MDU FSM, wait counter and timeout are built only when HAZARD_MDU_EN is defined.
module hazard_ctrl #(
  parameter int RFIDX_WIDTH = hazard_ctrl_pkg::RFIDX_WIDTH,
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   IDEX_memread,
  input  logic [RFIDX_WIDTH-1:0] IDEX_rd,
  input  logic                   IDEX_mdu,
  input  logic [RFIDX_WIDTH-1:0] IFID_rs1,
  input  logic [RFIDX_WIDTH-1:0] IFID_rs2,
  input  logic                   IFID_use_rs1,
  input  logic                   IFID_use_rs2,
  input  logic                   ex_redirect,
  input  logic                   mdu_done,
  output logic                   pc_stall,
  output logic                   ifid_stall,
  output logic                   idex_stall,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   exmem_bubble,
  output logic                   mdu_start,
  output logic                   mdu_timeout,
  output logic [CNT_WIDTH-1:0]   stall_cycles,
  output logic                   state_dbg
);

  import hazard_ctrl_pkg::*;

  hz_state_e state;
  logic      timeout_hit;
  logic      mdu_req;
  logic      load_use;

`ifdef HAZARD_MDU_EN
  localparam int WAIT_W = $clog2(MDU_TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_cnt;

  assign mdu_req     = IDEX_mdu;
  assign timeout_hit = (state == HZ_MDU_WAIT) && !mdu_done &&
                       (wait_cnt == WAIT_W'(MDU_TIMEOUT));

  // Redirect outranks an MDU launch: the MDU op in EX is on the squashed path.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= HZ_RUN;
      wait_cnt    <= '0;
      mdu_timeout <= 1'b0;
    end else begin
      case (state)
        HZ_RUN: begin
          if (!ex_redirect && IDEX_mdu) begin
            state    <= HZ_MDU_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        HZ_MDU_WAIT: begin
          if (mdu_done) begin
            state <= HZ_RUN;
          end else if (timeout_hit) begin
            state       <= HZ_RUN;
            mdu_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: state <= HZ_RUN;
      endcase
    end
  end
`else
  logic unused_mdu;

  assign state       = HZ_RUN;
  assign mdu_req     = 1'b0;
  assign timeout_hit = 1'b0;
  assign mdu_timeout = 1'b0;
  assign unused_mdu  = ^{IDEX_mdu, mdu_done};
`endif

  assign state_dbg = (state == HZ_MDU_WAIT);

  // A zero destination never creates a real dependency.
  assign load_use = IDEX_memread && (IDEX_rd != '0) &&
                    (((IDEX_rd == IFID_rs1) && IFID_use_rs1) ||
                     ((IDEX_rd == IFID_rs2) && IFID_use_rs2));

  always_comb begin
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    idex_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_bubble = 1'b0;
    mdu_start    = 1'b0;
    if (rstn) begin
      if (state == HZ_RUN) begin
        if (ex_redirect) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (mdu_req) begin
          mdu_start    = 1'b1;
          pc_stall     = 1'b1;
          ifid_stall   = 1'b1;
          idex_stall   = 1'b1;
          exmem_bubble = 1'b1;
        end else if (load_use) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
        end
      end else if (!mdu_done && !timeout_hit) begin
        pc_stall     = 1'b1;
        ifid_stall   = 1'b1;
        idex_stall   = 1'b1;
        exmem_bubble = 1'b1;
      end
    end
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_stall_cnt (
    .clk   (clk),
    .clr_n (rstn),
    .en    (pc_stall),
    .cnt   (stall_cycles)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, random load-use mix, MDU/timeout/reset sequences.
// Output bundle order: {pc_stall, ifid_stall, idex_stall, ifid_flush, idex_flush, exmem_bubble, mdu_start}.
module tb_hazard_ctrl;

`ifdef HAZARD_MDU_EN
  localparam bit MDU_ON = 1'b1;
`else
  localparam bit MDU_ON = 1'b0;
`endif

  localparam int TO = 8;

  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] LU   = 7'b1100100;
  localparam logic [6:0] RD   = 7'b0001100;
  localparam logic [6:0] MS   = 7'b1110011;
  localparam logic [6:0] WT   = 7'b1110010;

  typedef struct {
    logic       mr;
    logic [4:0] rd;
    logic       mdu;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       redir;
    logic       done;
    logic [6:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic IDEX_memread = 1'b0;
  logic [4:0] IDEX_rd = '0;
  logic IDEX_mdu = 1'b0;
  logic [4:0] IFID_rs1 = '0;
  logic [4:0] IFID_rs2 = '0;
  logic IFID_use_rs1 = 1'b0;
  logic IFID_use_rs2 = 1'b0;
  logic ex_redirect = 1'b0;
  logic mdu_done = 1'b0;
  logic pc_stall, ifid_stall, idex_stall, ifid_flush, idex_flush;
  logic exmem_bubble, mdu_start, mdu_timeout, state_dbg;
  logic [31:0] stall_cycles;

  int total = 0;
  int bad = 0;
  int exp_stalls = 0;
  logic [6:0] exp_q[$];
  vec_t tbl[10];

  always #5 clk = ~clk;

  hazard_ctrl #(
    .RFIDX_WIDTH (5),
    .MDU_TIMEOUT (TO),
    .CNT_WIDTH   (32)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .IDEX_memread (IDEX_memread),
    .IDEX_rd      (IDEX_rd),
    .IDEX_mdu     (IDEX_mdu),
    .IFID_rs1     (IFID_rs1),
    .IFID_rs2     (IFID_rs2),
    .IFID_use_rs1 (IFID_use_rs1),
    .IFID_use_rs2 (IFID_use_rs2),
    .ex_redirect  (ex_redirect),
    .mdu_done     (mdu_done),
    .pc_stall     (pc_stall),
    .ifid_stall   (ifid_stall),
    .idex_stall   (idex_stall),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_bubble (exmem_bubble),
    .mdu_start    (mdu_start),
    .mdu_timeout  (mdu_timeout),
    .stall_cycles (stall_cycles),
    .state_dbg    (state_dbg)
  );

  function automatic logic [6:0] outs();
    return {pc_stall, ifid_stall, idex_stall, ifid_flush, idex_flush, exmem_bubble, mdu_start};
  endfunction

  function automatic vec_t mk(logic mr, logic [4:0] rd, logic mdu, logic [4:0] rs1,
                              logic [4:0] rs2, logic u1, logic u2, logic redir,
                              logic done, logic [6:0] exp);
    vec_t v;
    v.mr = mr; v.rd = rd; v.mdu = mdu; v.rs1 = rs1; v.rs2 = rs2;
    v.u1 = u1; v.u2 = u2; v.redir = redir; v.done = done; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    IDEX_memread = v.mr;  IDEX_rd = v.rd;   IDEX_mdu = v.mdu;
    IFID_rs1 = v.rs1;     IFID_rs2 = v.rs2;
    IFID_use_rs1 = v.u1;  IFID_use_rs2 = v.u2;
    ex_redirect = v.redir; mdu_done = v.done;
  endtask

  // Drive one cycle, compare at the falling edge, leave time at posedge+1.
  task automatic step(input vec_t v, input string nm);
    logic [6:0] e;
    apply(v);
    exp_q.push_back(v.exp);
    if (v.exp[6]) exp_stalls++;
    @(negedge clk);
    e = exp_q.pop_front();
    chk(nm, 32'(outs()), 32'(e));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t idle, noise, v;
    idle  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);
    noise = mk(1, 5'd9, 1, 5'd9, 0, 1, 0, 1, 0, MDU_ON ? WT : RD);

    tbl[0] = mk(0, 0,     0, 0,     0,     0, 0, 0, 0, NONE);
    tbl[1] = mk(1, 5'd5,  0, 5'd5,  5'd1,  1, 0, 0, 0, LU);
    tbl[2] = mk(1, 5'd0,  0, 5'd3,  5'd0,  0, 1, 0, 0, NONE);
    tbl[3] = mk(1, 5'd5,  0, 5'd5,  5'd2,  0, 1, 0, 0, NONE);
    tbl[4] = mk(1, 5'd7,  0, 5'd1,  5'd7,  0, 1, 0, 0, LU);
    tbl[5] = mk(0, 5'd5,  0, 5'd5,  5'd5,  1, 1, 0, 0, NONE);
    tbl[6] = mk(1, 5'd5,  0, 5'd5,  5'd0,  1, 0, 1, 0, RD);
    tbl[7] = mk(0, 0,     0, 0,     0,     0, 0, 1, 0, RD);
    tbl[8] = mk(0, 0,     0, 0,     0,     0, 0, 0, 1, NONE);
    tbl[9] = mk(1, 5'd31, 0, 5'd4,  5'd31, 1, 1, 0, 0, LU);

    // Reset with a live load-use on the inputs: outputs must still be zero.
    apply(tbl[1]);
    #2;
    chk("reset_outs", 32'(outs()), 32'(NONE));
    chk("reset_cnt", stall_cycles, 0);
    chk("reset_timeout", 32'(mdu_timeout), 0);
    chk("reset_state", 32'(state_dbg), 0);
    apply(idle);
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;

    for (int i = 0; i < 10; i++) step(tbl[i], $sformatf("vec%0d", i));
    chk("lu_stall_cnt", stall_cycles, 32'(exp_stalls));

    // Random load-use/redirect mix over a small register range to force hits.
    for (int i = 0; i < 16; i++) begin
      logic lu;
      v = mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 0,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), NONE);
      lu = v.mr && (v.rd != 0) && ((v.rd == v.rs1 && v.u1) || (v.rd == v.rs2 && v.u2));
      v.exp = v.redir ? RD : (lu ? LU : NONE);
      step(v, $sformatf("rnd%0d", i));
    end
    chk("rnd_stall_cnt", stall_cycles, 32'(exp_stalls));

    // MDU: start, four waiting cycles with ignored hazards, then done.
    v = idle; v.mdu = 1; v.exp = MDU_ON ? MS : NONE;
    step(v, "mdu_start");
    chk("mdu_state_wait", 32'(state_dbg), 32'(MDU_ON));
    for (int i = 0; i < 4; i++) step(noise, $sformatf("mdu_wait%0d", i));
    v = idle; v.done = 1;
    step(v, "mdu_done_drop");
    chk("mdu_state_run", 32'(state_dbg), 0);
    step(tbl[1], "mdu_after_lu");
    chk("mdu_no_timeout", 32'(mdu_timeout), 0);
    chk("mdu_stall_cnt", stall_cycles, 32'(exp_stalls));

    // Timeout: no done; release exactly TO cycles after the start cycle.
    v = idle; v.mdu = 1; v.exp = MDU_ON ? MS : NONE;
    step(v, "to_start");
    v = idle; v.exp = MDU_ON ? WT : NONE;
    for (int i = 1; i < TO; i++) step(v, $sformatf("to_wait%0d", i));
    chk("to_not_yet", 32'(mdu_timeout), 0);
    step(idle, "to_release");
    chk("to_flag", 32'(mdu_timeout), 32'(MDU_ON));
    chk("to_state_run", 32'(state_dbg), 0);
    v = idle; v.done = 1;
    step(v, "to_late_done");
    step(idle, "to_idle");
    chk("to_sticky", 32'(mdu_timeout), 32'(MDU_ON));
    chk("to_stall_cnt", stall_cycles, 32'(exp_stalls));

    // Reset while waiting on the MDU.
    v = idle; v.mdu = 1; v.exp = MDU_ON ? MS : NONE;
    step(v, "rst_start");
    v.exp = MDU_ON ? WT : NONE;
    step(v, "rst_wait");
    rstn = 1'b0;
    exp_stalls = 0;
    #1;
    chk("rst_mid_outs", 32'(outs()), 32'(NONE));
    chk("rst_mid_state", 32'(state_dbg), 0);
    chk("rst_mid_timeout", 32'(mdu_timeout), 0);
    chk("rst_mid_cnt", stall_cycles, 0);
    @(posedge clk); #1;
    apply(idle);
    rstn = 1'b1;
    step(idle, "rst_rel_idle");
    v = idle; v.mdu = 1; v.exp = MDU_ON ? MS : NONE;
    step(v, "rst_rel_mdu");
    v = idle; v.done = 1;
    step(v, "rst_rel_done");
    chk("rst_stall_cnt", stall_cycles, 32'(exp_stalls));
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
